mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one 64x64 Booth multiplier between NREQ requesters using round-robin arbitration.
- Accepts one operand pair at a time and sequences the multiplier's start/clear protocol.
- Captures the 128-bit product and returns it on a shared response channel tagged with the requester id.
- Sits between client datapaths and the single multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ
TIMEOUT, 64, watchdog limit in cycles (used only with MUL_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*64  multiplier operands; slice i belongs to requester i
req_b  in  NREQ*64  multiplicand operands; slice i belongs to requester i
rsp_valid  out  1  product available
rsp_ready  in  1  consumer accepts product
rsp_id  out  IDW  requester index of the product
rsp_result  out  128  product
rsp_err  out  1  timeout flag; tied 0 without the macro
busy  out  1  high in every state except IDLE
mul_start  out  1  drives multiplier op_start
mul_clear  out  1  drives multiplier op_clear
mul_multiplier  out  64  drives multiplier operand
mul_multiplicand  out  64  drives multiplicand operand
mul_done  in  1  multiplier op_done
mul_result  in  128  multiplier result

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer rr_last = NREQ-1, so requester 0 has first priority.
- FSM, all outputs registered:
  - IDLE: arbitration is combinational over req_valid, searching from rr_last+1 with wrap-around. The winner i gets req_ready[i]=1 for exactly one cycle. On req_valid[i] & req_ready[i]: latch req_a/req_b slice i into mul_multiplier/mul_multiplicand, latch i into rsp_id, set rr_last=i, go to START. With no request, stay in IDLE and hold rr_last.
  - START: mul_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: mul_start=0. Operands stay stable until mul_done. On mul_done=1, capture mul_result into rsp_result, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_result stable until rsp_ready. On rsp_valid & rsp_ready: drop rsp_valid, go to CLEAR.
  - CLEAR: mul_clear=1 for exactly one cycle, then go to IDLE.
- Minimum gap between accepts is 4 cycles plus the multiplier latency.
- mul_start and mul_clear are never high in the same cycle; the multiplier's next-state is undefined for that input combination.
- req_ready is 0 in every state except IDLE, and is never high for more than one requester.
- A requester that deasserts req_valid before acceptance loses no state; arbitration re-evaluates each IDLE cycle.
- rsp_ready high with rsp_valid low is ignored.
- mul_done seen outside WAIT is ignored.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - No response is issued for the in-flight request.
  - The multiplier shares reset_n, so both blocks resynchronise in INIT/IDLE.
- Operands pass through unmodified. Signedness follows the multiplier's radix-4 Booth (two's complement).

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without mul_done: set rsp_result=0, rsp_err=1, rsp_valid=1, go to RESP.
  - The normal CLEAR step then aborts the multiplier.
  - rsp_err clears on the response handshake.
- Undefined: no counter; rsp_err is constant 0; WAIT holds indefinitely.

Decomposition:
- Package mul_arb_pkg:
  - state typedef: IDLE, START, WAIT, RESP, CLEAR.
  - Constants OPW=64 and RESW=128.
- Sub-module mul_rr_pick: combinational round-robin selector.
  - Inputs: req_valid, rr_last.
  - Outputs: grant one-hot, grant index, any.

Test Plan:
- Only req0 with a=3, b=5 (behavioural multiplier model) -> single mul_start pulse; rsp_valid with rsp_id=0, rsp_result=15; one mul_clear pulse one cycle after the handshake.
- req_valid=4'b1111 held after reset -> grants in order 0,1,2,3,0,1; products match each operand pair; req_ready never multi-hot.
- rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_result stable; no req_ready; no mul_clear until the handshake.
- req2 with a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> rsp_id=2, rsp_result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE.
- reset_n low for 2 cycles during WAIT -> all outputs 0, no rsp_valid; after release, req1 a=7, b=6 returns 42 with rsp_id=1.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=8, and a stub that never asserts mul_done -> rsp_valid with rsp_err=1, rsp_result=0 after 8 WAIT cycles; mul_clear follows the handshake; the next request completes with rsp_err=0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int unsigned OPW  = 64;
  localparam int unsigned RESW = 128;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    CLEAR
  } state_e;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester/response bundle between client datapaths and mul_share_arbiter.
interface mul_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  import mul_arb_pkg::*;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_result;
  logic                rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/mul_rr_pick.sv
// Combinational round-robin selector: first valid requester after rr_last, wrapping.
module mul_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_last_i,
  output logic [NREQ-1:0] grant_oh_c_o,
  output logic [IDW-1:0]  grant_idx_c_o,
  output logic            any_c_o
);

  always_comb begin
    grant_oh_c_o  = '0;
    grant_idx_c_o = '0;
    any_c_o       = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_last_i) + k) % NREQ;
      if (!any_c_o && ((req_valid_i & (NREQ'(1) << idx)) != '0)) begin
        grant_oh_c_o  = NREQ'(1) << idx;
        grant_idx_c_o = IDW'(idx);
        any_c_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one Booth multiplier among NREQ requesters with round-robin arbitration.
// Optional watchdog on the multiplier wait: define MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mul_share_arbiter_if.slave   bus,
  output logic                 busy,
  output logic                 mul_start,
  output logic                 mul_clear,
  output logic [OPW-1:0]       mul_multiplier,
  output logic [OPW-1:0]       mul_multiplicand,
  input  logic                 mul_done,
  input  logic [RESW-1:0]      mul_result
);

  if ((32'd1 << IDW) < NREQ || TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_param
    $error("mul_share_arbiter: IDW too narrow for NREQ or TIMEOUT out of range");
  end

  state_e          state_q;
  logic [IDW-1:0]  rr_last_q;
  logic [IDW-1:0]  gnt_idx_q;
  logic [NREQ-1:0] req_ready_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [RESW-1:0] rsp_result_q;
  logic            busy_q;
  logic            mul_start_q;
  logic            mul_clear_q;
  logic [OPW-1:0]  mul_a_q;
  logic [OPW-1:0]  mul_b_q;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  mul_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid_i   (bus.req_valid),
    .rr_last_i     (rr_last_q),
    .grant_oh_c_o  (grant_oh),
    .grant_idx_c_o (grant_idx),
    .any_c_o       (grant_any)
  );

`ifdef MUL_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Sequencer: grant -> start pulse -> wait done -> respond -> clear pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_last_q    <= IDW'(NREQ - 1);
      gnt_idx_q    <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_clear_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Ready is a one-cycle offer; an unused offer lapses and arbitration reruns.
          if (req_ready_q == '0) begin
            req_ready_q <= grant_any ? grant_oh : '0;
            gnt_idx_q   <= grant_idx;
          end else begin
            req_ready_q <= '0;
            if ((bus.req_valid & req_ready_q) != '0) begin
              mul_a_q     <= bus.req_a[32'(gnt_idx_q) * OPW +: OPW];
              mul_b_q     <= bus.req_b[32'(gnt_idx_q) * OPW +: OPW];
              rsp_id_q    <= gnt_idx_q;
              rr_last_q   <= gnt_idx_q;
              mul_start_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          mul_start_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
          wait_cnt_q  <= '0;
`endif
          state_q     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_result_q <= mul_result;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            mul_clear_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          mul_clear_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign busy            = busy_q;
  assign mul_start       = mul_start_q;
  assign mul_clear       = mul_clear_q;
  assign mul_multiplier  = mul_a_q;
  assign mul_multiplicand = mul_b_q;

endmodule
